input_requester: RTL and testbench
==================================

Name: input_requester

Overview:
- Input-side requester for one router input port; it is the initiator end of the request/grant handshake that each output arbiter answers.
- Buffers incoming single-word packets in a small FIFO and decodes the destination of the head packet.
- Raises a one-hot request to that destination's output arbiter, holds it until granted, then forwards the word.
- Four instances sit in front of the four output arbiters.

Parameters:
DATA_W, 16, packet word width; bits [DATA_W-1:DATA_W-2] are the destination field.
DEPTH, 4, FIFO depth in words; power of 2, >= 2.
STARVE_LIMIT, 12, wait cycles at which the starvation flag asserts; must be <= 2^WAIT_W-1.
WAIT_W, 4, width of the saturating wait counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream word valid.
in_data  in  DATA_W  upstream packet word.
in_ready  out  1  FIFO can accept a word.
req  out  4  one-hot request to output arbiters; bit0=one, bit1=two, bit2=three, bit3=four.
grant  in  4  grant from the output arbiters, same bit order; combinational from req.
out_valid  out  1  forwarded word valid, one-cycle pulse.
out_data  out  DATA_W  forwarded word.
out_dest  out  2  destination of the forwarded word.
starve  out  1  head request has waited >= STARVE_LIMIT cycles.
err_spurious  out  1  sticky; grant seen on a non-requested line.
fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, req=0, out_valid=0, out_data=0, out_dest=0, starve=0, err_spurious=0, wait counter=0, in_ready=1.
- Push: in_valid && in_ready at an edge writes in_data. in_ready = (count != DEPTH), derived from registered count only.
- Full FIFO: in_ready=0 even if a pop happens in the same cycle; no combinational ready-through path.
- Destination decode: dest = head[DATA_W-1:DATA_W-2]; 00->one, 01->two, 10->three, 11->four.
- IDLE: req=0. Moves to REQ at the edge after the FIFO becomes non-empty.
- REQ: req = onehot(dest of head). This is a Moore output and is stable for the whole wait.
  - A request is never retracted or retargeted until granted.
- Grant accepted (in REQ, grant & req != 0, sampled at an edge):
  - Pop the head.
  - Register out_data=head, out_dest=dest, out_valid=1 for exactly the next cycle.
  - Latency is 1 cycle from grant edge to out_valid.
- After a pop: stay in REQ if words remain (back-to-back grants allow one word per cycle); otherwise go to IDLE.
- Simultaneous push and pop when not full: both occur and count is unchanged.
- Push into an empty FIFO: the head becomes visible and req asserts on the next cycle (1-cycle minimum push-to-req).
- Wait counter: increments each REQ cycle without grant and saturates at 2^WAIT_W-1. It clears to 0 on grant or on entering IDLE.
- starve = (wait >= STARVE_LIMIT), registered. Informational only; behaviour is unchanged.
- Spurious grant: any grant bit set where req is 0 (including in IDLE) sets err_spurious until reset. That bit is otherwise ignored.
- A grant with multiple bits set, one of them matching, is accepted and also sets err_spurious.
- Reset mid-wait: the request drops immediately (async) and the buffered packets are discarded.

Decomposition:
- Shared package router_pkg:
  - NUM_PORTS=4.
  - 2-bit dest encoding constants DEST_ONE..DEST_FOUR.
  - function dest_to_onehot.
  - state enum {IDLE, REQ}.
- Sub-module sync_fifo (DATA_W, DEPTH): registered count, wrap-around pointers, full/empty flags. Reused by other input ports.

Test Plan:
- Push 0x4ABC (dest 01) into an idle block; tie grant=req on the cycle after req=0010 -> req=0010 then 0000; out_valid pulse with out_data=0x4ABC, out_dest=1; fifo_count 1->0.
- Push 4 words (dest 00,11,10,00) with grant=req every cycle -> req sequence 0001,1000,0100,0001 on consecutive cycles; four consecutive out_valid pulses in order.
- Fill to DEPTH=4 with grant=0 -> in_ready=0 and a fifth in_valid is dropped; count stays 4.
  - Then grant once with in_valid high -> pop occurs, in_ready returns to 1 the next cycle.
- Hold grant=0 with the head pending -> starve rises after 12 REQ cycles, wait saturates at 15, req stays stable; a grant clears starve the next cycle.
- With req=0001, drive grant=0100 -> no pop, err_spurious=1 and sticky; a later grant=0001 pops normally.
- Assert rst_n=0 mid-wait with 3 words buffered -> req=0 immediately, count=0, in_ready=1, err_spurious=0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: port count, destination encoding, requester states.
package router_pkg;

   localparam int unsigned NUM_PORTS = 4;

   localparam logic [1:0] DEST_ONE   = 2'd0;
   localparam logic [1:0] DEST_TWO   = 2'd1;
   localparam logic [1:0] DEST_THREE = 2'd2;
   localparam logic [1:0] DEST_FOUR  = 2'd3;

   typedef enum logic {IDLE, REQ} req_state_t;

   // Map a 2-bit destination field onto the one-hot arbiter request lines.
   function automatic logic [NUM_PORTS-1:0] dest_to_onehot(input logic [1:0] dest);
      logic [NUM_PORTS-1:0] oh;
      oh = '0;
      unique case (dest)
         DEST_ONE:   oh = 4'b0001;
         DEST_TWO:   oh = 4'b0010;
         DEST_THREE: oh = 4'b0100;
         DEST_FOUR:  oh = 4'b1000;
         default:    oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and wrap-around pointers.
module sync_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [DATA_W-1:0]      wdata,
   output logic [DATA_W-1:0]      rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              do_push;
   logic              do_pop;

   // Guard against overflow/underflow regardless of caller behaviour.
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign rdata = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/input_requester.sv
// Router input-port requester: buffers words, requests the head's output arbiter,
// and forwards the word one cycle after the grant.
module input_requester
   import router_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 12,
   parameter int unsigned WAIT_W       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   in_ready,
   output logic [NUM_PORTS-1:0]   req,
   input  logic [NUM_PORTS-1:0]   grant,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data,
   output logic [1:0]             out_dest,
   output logic                   starve,
   output logic                   err_spurious,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   req_state_t        state_q;
   logic [DATA_W-1:0] head;
   logic [1:0]        head_dest;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     count;
   logic              push;
   logic              accept;
   logic [WAIT_W-1:0] wait_q;
   logic [WAIT_W-1:0] wait_d;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [1:0]        out_dest_q;
   logic              starve_q;
   logic              err_q;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (accept),
      .wdata (in_data),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   // Request is a pure function of registered state and the registered FIFO head,
   // so it cannot glitch or retarget while waiting.
   always_comb begin
      head_dest = head[DATA_W-1 -: 2];
      in_ready  = !fifo_full;
      push      = in_valid && in_ready;
      req       = (state_q == REQ) ? dest_to_onehot(head_dest) : '0;
      accept    = (state_q == REQ) && |(grant & req);
   end

   // Saturating wait count; cleared whenever the head is not waiting.
   always_comb begin
      wait_d = '0;
      if (state_q == REQ && !accept) begin
         wait_d = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
      end
   end

   // Control FSM plus all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_dest_q  <= '0;
         wait_q      <= '0;
         starve_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE:    if (!fifo_empty) state_q <= REQ;
            REQ:     if (accept && count == CW'(1) && !push) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         out_valid_q <= accept;
         if (accept) begin
            out_data_q <= head;
            out_dest_q <= head_dest;
         end
         wait_q   <= wait_d;
         starve_q <= (wait_d >= WAIT_W'(STARVE_LIMIT));
         err_q    <= err_q | (|(grant & ~req));
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_dest     = out_dest_q;
   assign starve       = starve_q;
   assign err_spurious = err_q;
   assign fifo_count   = count;

endmodule

// File: tb/tb_input_requester.sv
// Directed bench for input_requester: table-driven handshake vectors plus
// hand-written starvation, spurious-grant and reset sequences.
module tb_input_requester;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic        out_valid;
   logic [15:0] out_data;
   logic [1:0]  out_dest;
   logic        starve;
   logic        err_spurious;
   logic [2:0]  fifo_count;

   int checks;
   int failures;

   typedef struct {
      logic        in_valid;
      logic [15:0] in_data;
      logic [3:0]  grant;
      logic [3:0]  exp_req;
      logic        exp_ov;
      logic [15:0] exp_od;
      logic [1:0]  exp_dest;
      logic [2:0]  exp_cnt;
      logic        exp_rdy;
   } vec_t;

   vec_t vecs[$];

   input_requester dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .req          (req),
      .grant        (grant),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_dest     (out_dest),
      .starve       (starve),
      .err_spurious (err_spurious),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic v, input logic [15:0] d, input logic [3:0] g,
                               input logic [3:0] er, input logic eov, input logic [15:0] eod,
                               input logic [1:0] ed, input logic [2:0] ec, input logic erdy);
      vec_t r;
      r.in_valid = v;  r.in_data = d;   r.grant = g;
      r.exp_req  = er; r.exp_ov  = eov; r.exp_od = eod;
      r.exp_dest = ed; r.exp_cnt = ec;  r.exp_rdy = erdy;
      return r;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      grant    = '0;

      // Each row: check outputs of the current cycle, then drive that cycle's inputs.
      // Single word, dest 01.
      vecs.push_back(mk(1, 16'h4ABC, 4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd0, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd1, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0010, 4'b0010, 0, 16'h0,    2'd0, 3'd1, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0000, 1, 16'h4ABC, 2'd1, 3'd0, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd0, 1));
      // Four words, dest 00,11,10,00, granted back to back.
      vecs.push_back(mk(1, 16'h0111, 4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd0, 1));
      vecs.push_back(mk(1, 16'hC222, 4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd1, 1));
      vecs.push_back(mk(1, 16'h8333, 4'b0001, 4'b0001, 0, 16'h0,    2'd0, 3'd2, 1));
      vecs.push_back(mk(1, 16'h0444, 4'b1000, 4'b1000, 1, 16'h0111, 2'd0, 3'd2, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0100, 4'b0100, 1, 16'hC222, 2'd3, 3'd2, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0001, 4'b0001, 1, 16'h8333, 2'd2, 3'd1, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0000, 1, 16'h0444, 2'd0, 3'd0, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd0, 1));
      // Fill to full, fifth word dropped, then pop with in_valid held.
      vecs.push_back(mk(1, 16'h1001, 4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd0, 1));
      vecs.push_back(mk(1, 16'h1002, 4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd1, 1));
      vecs.push_back(mk(1, 16'h1003, 4'b0000, 4'b0001, 0, 16'h0,    2'd0, 3'd2, 1));
      vecs.push_back(mk(1, 16'h1004, 4'b0000, 4'b0001, 0, 16'h0,    2'd0, 3'd3, 1));
      vecs.push_back(mk(1, 16'h1005, 4'b0000, 4'b0001, 0, 16'h0,    2'd0, 3'd4, 0));
      vecs.push_back(mk(1, 16'h1005, 4'b0001, 4'b0001, 0, 16'h0,    2'd0, 3'd4, 0));
      vecs.push_back(mk(1, 16'h1005, 4'b0000, 4'b0001, 1, 16'h1001, 2'd0, 3'd3, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0001, 4'b0001, 0, 16'h0,    2'd0, 3'd4, 0));
      vecs.push_back(mk(0, 16'h0,    4'b0001, 4'b0001, 1, 16'h1002, 2'd0, 3'd3, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0001, 4'b0001, 1, 16'h1003, 2'd0, 3'd2, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0001, 1, 16'h1004, 2'd0, 3'd1, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0001, 4'b0001, 0, 16'h0,    2'd0, 3'd1, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0000, 1, 16'h1005, 2'd0, 3'd0, 1));
      vecs.push_back(mk(0, 16'h0,    4'b0000, 4'b0000, 0, 16'h0,    2'd0, 3'd0, 1));

      // Reset state.
      #12;
      chk("reset req", 32'(req), 32'h0);
      chk("reset count", 32'(fifo_count), 32'h0);
      chk("reset in_ready", 32'(in_ready), 32'h1);
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset out_data", 32'(out_data), 32'h0);
      chk("reset starve", 32'(starve), 32'h0);
      chk("reset err", 32'(err_spurious), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         chk($sformatf("vec%0d req", i), 32'(req), 32'(vecs[i].exp_req));
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov) begin
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
            chk($sformatf("vec%0d out_dest", i), 32'(out_dest), 32'(vecs[i].exp_dest));
         end
         chk($sformatf("vec%0d count", i), 32'(fifo_count), 32'(vecs[i].exp_cnt));
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
         chk($sformatf("vec%0d starve", i), 32'(starve), 32'h0);
         chk($sformatf("vec%0d err", i), 32'(err_spurious), 32'h0);
         in_valid = vecs[i].in_valid;
         in_data  = vecs[i].in_data;
         grant    = vecs[i].grant;
         step();
      end
      in_valid = 1'b0;
      grant    = '0;

      // Starvation: head dest 11 waits ungranted; starve at 12, wait saturates at 15.
      in_valid = 1'b1;
      in_data  = 16'hC0DE;
      step();
      in_valid = 1'b0;
      step();
      for (int k = 0; k <= 20; k++) begin
         chk($sformatf("starve k%0d", k), 32'(starve), (k >= 12) ? 32'h1 : 32'h0);
         chk($sformatf("starve req k%0d", k), 32'(req), 32'h8);
         chk($sformatf("wait k%0d", k), 32'(dut.wait_q), (k > 15) ? 32'd15 : 32'(k));
         if (k == 20) grant = 4'b1000;
         step();
      end
      grant = '0;
      chk("starve cleared", 32'(starve), 32'h0);
      chk("starve pop valid", 32'(out_valid), 32'h1);
      chk("starve pop data", 32'(out_data), 32'hC0DE);
      chk("starve pop dest", 32'(out_dest), 32'h3);
      chk("starve pop req", 32'(req), 32'h0);

      // Spurious grant on a non-requested line.
      in_valid = 1'b1;
      in_data  = 16'h0055;
      step();
      in_valid = 1'b0;
      step();
      chk("spur req", 32'(req), 32'h1);
      chk("spur err before", 32'(err_spurious), 32'h0);
      grant = 4'b0100;
      step();
      grant = '0;
      chk("spur err set", 32'(err_spurious), 32'h1);
      chk("spur no pop", 32'(out_valid), 32'h0);
      chk("spur count", 32'(fifo_count), 32'h1);
      chk("spur req held", 32'(req), 32'h1);
      step();
      chk("spur err sticky", 32'(err_spurious), 32'h1);
      grant = 4'b0001;
      step();
      grant = '0;
      chk("spur later pop valid", 32'(out_valid), 32'h1);
      chk("spur later pop data", 32'(out_data), 32'h0055);
      chk("spur later count", 32'(fifo_count), 32'h0);
      chk("spur err still", 32'(err_spurious), 32'h1);

      // Reset while waiting with three words buffered.
      for (int w = 1; w <= 3; w++) begin
         in_valid = 1'b1;
         in_data  = 16'h8000 | 16'(w);
         step();
      end
      in_valid = 1'b0;
      chk("prerst count", 32'(fifo_count), 32'h3);
      chk("prerst req", 32'(req), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst req", 32'(req), 32'h0);
      chk("rst count", 32'(fifo_count), 32'h0);
      chk("rst in_ready", 32'(in_ready), 32'h1);
      chk("rst err", 32'(err_spurious), 32'h0);
      #3;
      rst_n = 1'b1;
      step();
      step();
      chk("postrst req", 32'(req), 32'h0);
      chk("postrst count", 32'(fifo_count), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
